gate_truth_table_checker: RTL and testbench

Self-test sequencer for a combinational gate under test, such as the two-input `or_gate`. It drives every input combination onto the gate in ascending order and waits a programmable settle time on each. After settling it samples the gate output and compares it against a truth table supplied at start. It reports done/pass, the number of mismatches and the first failing input vector, which replaces a manual bench sweep with an on-chip check.

---
 rtl/gate_truth_table_checker.sv | 103 ++++++++++
 tb/tb_gate_truth_table_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_checker.sv
// Self-test sequencer: sweeps every input vector of a combinational gate, lets each
// settle for DWELL cycles, samples the gate output and tallies mismatches against a truth table.
module gate_truth_table_checker #(
  parameter int N_IN  = 2,
  parameter int DWELL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      gate_in,
  input  logic                 gate_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int NVEC = 2**N_IN;
  localparam int DW   = $clog2(DWELL) + 1;
  localparam int EW   = N_IN + 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST   = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t            state, state_next;
  logic [NVEC-1:0]   exp_reg;
  logic [N_IN-1:0]   vec;
  logic [DW-1:0]     dwell_cnt;
  logic              first_err;
  logic              mismatch;
  logic [EW-1:0]     err_next;

  assign gate_in  = vec;
  assign mismatch = gate_out != exp_reg[vec];
  // The final pass verdict must include the mismatch of the last vector's own sample.
  assign err_next = err_count + EW'(mismatch);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (dwell_cnt == DWELL_LAST) state_next = SAMPLE;
      SAMPLE:  state_next = (vec == VEC_LAST) ? IDLE : SETTLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_reg   <= '0;
      vec       <= '0;
      dwell_cnt <= '0;
      first_err <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_reg   <= expected;
            vec       <= '0;
            dwell_cnt <= '0;
            first_err <= 1'b0;
            err_count <= '0;
            fail_idx  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        SETTLE: dwell_cnt <= dwell_cnt + DW'(1);
        SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_err) begin
            fail_idx  <= vec;
            first_err <= 1'b1;
          end
          if (vec == VEC_LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == '0);
          end else begin
            vec       <= vec + N_IN'(1);
            dwell_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: two instances (2-input/DWELL=2 and 3-input/DWELL=1)
// driven by a selectable gate model, compared every cycle against a cycle-count reference model.
module tb_gate_truth_table_checker;

  localparam int NA = 2, DA = 2, NB = 3, DB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [3:0]  exp_a = '0;
  logic [7:0]  exp_b = '0;
  logic [1:0]  gin_a;
  logic [2:0]  gin_b;
  logic        gout_a, gout_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0]  err_a;
  logic [3:0]  err_b;
  logic [1:0]  fidx_a;
  logic [2:0]  fidx_b;

  // Gate models: 0=OR, 1=AND, 2=stuck-at-1, 3=arbitrary table, 4=XOR (parity)
  int         mode_a = 0, mode_b = 4;
  logic [7:0] tab_a = '0, tab_b = '0;

  int checks = 0;
  int failures = 0;

  // Reference model state, index 0 = instance a, 1 = instance b
  int         m_busy[2] = '{0, 0};
  int         m_done[2] = '{0, 0};
  int         m_pass[2] = '{0, 0};
  int         m_err[2]  = '{0, 0};
  int         m_fail[2] = '{0, 0};
  int         m_gin[2]  = '{0, 0};
  int         m_t[2]    = '{0, 0};
  logic [7:0] m_exp[2]  = '{8'h00, 8'h00};

  always #5 clk = ~clk;

  gate_truth_table_checker #(.N_IN(NA), .DWELL(DA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(exp_a), .gate_in(gin_a),
    .gate_out(gout_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_idx(fidx_a)
  );

  gate_truth_table_checker #(.N_IN(NB), .DWELL(DB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(exp_b), .gate_in(gin_b),
    .gate_out(gout_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_idx(fidx_b)
  );

  function automatic logic gate_eval(input int mode, input logic [7:0] tab, input int v, input int nbits);
    case (mode)
      0:       return v != 0;
      1:       return v == (1 << nbits) - 1;
      2:       return 1'b1;
      3:       return tab[v];
      default: return ($countones(v) % 2) == 1;
    endcase
  endfunction

  assign gout_a = gate_eval(mode_a, tab_a, int'(gin_a), NA);
  assign gout_b = gate_eval(mode_b, tab_b, int'(gin_b), NB);

  function automatic void count_errs(input int mode, input logic [7:0] tab, input logic [7:0] ex,
                                     input int n, input int nbits, output int err, output int fail);
    err = 0;
    fail = 0;
    for (int k = 0; k < n; k++) begin
      if (gate_eval(mode, tab, k, nbits) != ex[k]) begin
        if (err == 0) fail = k;
        err++;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // Vector k of a sweep starting at edge 0 is sampled at edge (k+1)*(DWELL+1), so after t edges
  // exactly t/(DWELL+1) vectors have been judged.
  always @(posedge clk or posedge rst) begin : model
    int nv, per, nb, md, e, f;
    logic st;
    logic [7:0] ex, tb_tab;
    for (int i = 0; i < 2; i++) begin
      nv  = (i == 0) ? (1 << NA) : (1 << NB);
      per = (i == 0) ? DA + 1 : DB + 1;
      nb  = (i == 0) ? NA : NB;
      md  = (i == 0) ? mode_a : mode_b;
      st  = (i == 0) ? start_a : start_b;
      ex  = (i == 0) ? {4'b0, exp_a} : exp_b;
      tb_tab = (i == 0) ? tab_a : tab_b;
      if (rst) begin
        m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0;
        m_err[i] = 0; m_fail[i] = 0; m_gin[i] = 0; m_t[i] = 0;
      end else if (m_busy[i] == 0) begin
        if (st) begin
          m_busy[i] = 1; m_done[i] = 0; m_pass[i] = 0;
          m_err[i] = 0; m_fail[i] = 0; m_gin[i] = 0; m_t[i] = 0;
          m_exp[i] = ex;
        end
      end else begin
        m_t[i]++;
        count_errs(md, tb_tab, m_exp[i], m_t[i] / per, nb, e, f);
        m_err[i] = e;
        m_fail[i] = f;
        if (m_t[i] == nv * per) begin
          m_busy[i] = 0;
          m_done[i] = 1;
          m_pass[i] = (e == 0) ? 1 : 0;
          m_gin[i] = nv - 1;
        end else begin
          m_gin[i] = m_t[i] / per;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("a_gate_in",   int'(gin_a),  m_gin[0]);
      checkOutput("a_busy",      int'(busy_a), m_busy[0]);
      checkOutput("a_done",      int'(done_a), m_done[0]);
      checkOutput("a_pass",      int'(pass_a), m_pass[0]);
      checkOutput("a_err_count", int'(err_a),  m_err[0]);
      checkOutput("a_fail_idx",  int'(fidx_a), m_fail[0]);
      checkOutput("b_gate_in",   int'(gin_b),  m_gin[1]);
      checkOutput("b_busy",      int'(busy_b), m_busy[1]);
      checkOutput("b_done",      int'(done_b), m_done[1]);
      checkOutput("b_pass",      int'(pass_b), m_pass[1]);
      checkOutput("b_err_count", int'(err_b),  m_err[1]);
      checkOutput("b_fail_idx",  int'(fidx_b), m_fail[1]);
    end
  end

  // Runs one sweep on the chosen instance; optional start pulse while busy and random noise on
  // start/expected after the start edge, none of which may disturb the sweep.
  task automatic applyStimulus(input int inst, input logic [7:0] ex, input int mode,
                               input int pulse_at, input bit noisy);
    int cycles, total;
    logic st;
    total = (inst == 0) ? (1 << NA) * (DA + 1) : (1 << NB) * (DB + 1);
    if (inst == 0) begin exp_a = ex[3:0]; mode_a = mode; end
    else           begin exp_b = ex;      mode_b = mode; end
    @(posedge clk); #2;
    if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #2;
    start_a = 1'b0;
    start_b = 1'b0;
    checkOutput("start_busy",       int'(inst == 0 ? busy_a : busy_b), 1);
    checkOutput("start_done_clear", int'(inst == 0 ? done_a : done_b), 0);
    checkOutput("start_gate_in",    int'(inst == 0 ? gin_a : gin_b), 0);
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clk); #2;
      cycles++;
      if ((inst == 0) ? done_a : done_b) break;
      st = (cycles == pulse_at) || (noisy && $urandom_range(0, 3) == 0);
      if (inst == 0) start_a = st; else start_b = st;
      if (noisy) begin
        if (inst == 0) exp_a = 4'($urandom);
        else           exp_b = 8'($urandom);
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    checkOutput("sweep_cycles", cycles, total);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_gate_in", int'(gin_a),  0);
    checkOutput("reset_busy",    int'(busy_a), 0);
    checkOutput("reset_done",    int'(done_a), 0);
    checkOutput("reset_pass",    int'(pass_a), 0);
    checkOutput("reset_err",     int'(err_a),  0);
    checkOutput("reset_fail",    int'(fidx_a), 0);
    #3 rst = 1'b0;

    applyStimulus(0, 8'h0E, 0, -1, 1'b0);
    checkOutput("or_pass", int'(pass_a), 1);
    checkOutput("or_err",  int'(err_a),  0);
    checkOutput("or_last_vec", int'(gin_a), 3);

    applyStimulus(0, 8'h0E, 1, -1, 1'b0);
    checkOutput("and_pass", int'(pass_a), 0);
    checkOutput("and_err",  int'(err_a),  2);
    checkOutput("and_fail", int'(fidx_a), 1);

    applyStimulus(0, 8'h0E, 2, -1, 1'b0);
    checkOutput("stuck_pass", int'(pass_a), 0);
    checkOutput("stuck_err",  int'(err_a),  1);
    checkOutput("stuck_fail", int'(fidx_a), 0);
    applyStimulus(0, 8'h0F, 2, -1, 1'b0);
    checkOutput("stuck_all1_pass", int'(pass_a), 1);
    checkOutput("stuck_all1_err",  int'(err_a),  0);

    applyStimulus(0, 8'h0E, 0, 5, 1'b0);
    checkOutput("busy_start_pass", int'(pass_a), 1);

    exp_a = 4'hE;
    mode_a = 1;
    @(posedge clk); #2 start_a = 1'b1;
    @(posedge clk); #2 start_a = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    checkOutput("pre_reset_gate_in", int'(gin_a), 2);
    checkOutput("pre_reset_err",     int'(err_a), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_busy",    int'(busy_a), 0);
    checkOutput("mid_reset_gate_in", int'(gin_a),  0);
    checkOutput("mid_reset_done",    int'(done_a), 0);
    checkOutput("mid_reset_err",     int'(err_a),  0);
    #10 rst = 1'b0;
    applyStimulus(0, 8'h0E, 0, -1, 1'b0);
    checkOutput("post_reset_pass", int'(pass_a), 1);

    applyStimulus(1, 8'b1001_0110, 4, -1, 1'b0);
    checkOutput("xor3_pass", int'(pass_b), 1);
    checkOutput("xor3_err",  int'(err_b),  0);
    applyStimulus(1, 8'b0001_0110, 4, -1, 1'b0);
    checkOutput("xor3_flip_pass", int'(pass_b), 0);
    checkOutput("xor3_flip_err",  int'(err_b),  1);
    checkOutput("xor3_flip_fail", int'(fidx_b), 7);

    for (int n = 0; n < 24; n++) begin
      int inst;
      inst = int'($urandom_range(0, 1));
      if (inst == 0) tab_a = 8'($urandom);
      else           tab_b = 8'($urandom);
      applyStimulus(inst, 8'($urandom), int'($urandom_range(0, 4)), -1, 1'b1);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
